config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 146 ++++++++++++++
 tb/tb_config_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Streams bitstream words LSB-first into a scan chain while capturing
// the old chain contents from scan_out as readback words.
module config_loader #(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  scan_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  cfg_scan_in,
  output logic                  cfg_scan_en,
  input  logic                  cfg_scan_out,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int PW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LENGTH - 1);
  localparam logic [PW-1:0] WEND = PW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [PW-1:0]         wpos;
  logic [WORD_WIDTH-1:0] sbuf;
  logic [WORD_WIDTH-1:0] rb;
  logic [WORD_WIDTH-1:0] rb_cap;
  logic [WORD_WIDTH-1:0] sbuf_sh;
  logic [CW-1:0]         cnt_inc;
  logic [PW-1:0]         wpos_inc;
  logic                  last_bit;
  logic                  word_end;
  logic                  hs;

  assign last_bit = (bit_cnt == LAST);
  assign word_end = (wpos == WEND) || last_bit;
  assign cnt_inc  = bit_cnt + CW'(1);
  assign wpos_inc = wpos + PW'(1);
  assign sbuf_sh  = sbuf >> 1;
  assign hs       = in_valid && in_ready;

  always_comb begin
    rb_cap       = rb;
    rb_cap[wpos] = cfg_scan_out;
  end

  // Ready is registered, so it is computed for the position shifted next.
  function automatic logic rdy(
    input logic [PW-1:0] w,
    input logic [CW-1:0] c
  );
    return (w == WEND) && (c != LAST);
  endfunction

  always_ff @(posedge scan_clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      wpos        <= '0;
      sbuf        <= '0;
      rb          <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      in_ready    <= 1'b0;
      cfg_scan_in <= 1'b0;
      cfg_scan_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            bit_cnt  <= '0;
            wpos     <= '0;
            rb       <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        FETCH: begin
          if (hs) begin
            state       <= SHIFT;
            sbuf        <= in_data;
            wpos        <= '0;
            cfg_scan_en <= 1'b1;
            cfg_scan_in <= in_data[0];
            in_ready    <= rdy('0, bit_cnt);
          end
        end
        SHIFT: begin
          bit_cnt <= cnt_inc;
          if (word_end) begin
            rd_data  <= rb_cap;
            rd_valid <= 1'b1;
            rb       <= '0;
          end else begin
            rb <= rb_cap;
          end
          if (last_bit) begin
            state       <= DONE;
            cfg_scan_en <= 1'b0;
            cfg_scan_in <= 1'b0;
            in_ready    <= 1'b0;
            done        <= 1'b1;
          end else if (word_end && hs) begin
            sbuf        <= in_data;
            wpos        <= '0;
            cfg_scan_in <= in_data[0];
            in_ready    <= rdy('0, cnt_inc);
          end else if (word_end) begin
            // Starved: park in FETCH with the chain frozen.
            state       <= FETCH;
            cfg_scan_en <= 1'b0;
            cfg_scan_in <= 1'b0;
            in_ready    <= 1'b1;
          end else begin
            sbuf        <= sbuf_sh;
            wpos        <= wpos_inc;
            cfg_scan_in <= sbuf_sh[0];
            in_ready    <= rdy(wpos_inc, cnt_inc);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: 12-bit chain model on the scan port, table
// vectors, random passes against a word-level model, corner sequences.
`timescale 1ns/1ps
module tb_config_loader;

  localparam int CL = 12;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          scan_in;
  logic          scan_en;
  logic          scan_out;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;

  logic [CL-1:0] chain;
  logic [CL-1:0] chain_init;
  logic          chain_load = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) dut (
    .scan_clk    (clk),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cfg_scan_in (scan_in),
    .cfg_scan_en (scan_en),
    .cfg_scan_out(scan_out),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .done        (done)
  );

  // Downstream chain: shifts toward bit 0, tail is bit 0.
  always @(posedge clk) begin
    if (chain_load) chain <= chain_init;
    else if (scan_en) chain <= {scan_in, chain[CL-1:1]};
  end
  assign scan_out = chain[0];

  typedef struct {
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    logic [CL-1:0] pre;
    int            gap;
    logic [CL-1:0] bits;
    logic [WW-1:0] rd0;
    logic [WW-1:0] rd1;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CL-1:0] model_bits(input logic [WW-1:0] w0,
                                               input logic [WW-1:0] w1);
    logic [WW-1:0] ws[2];
    logic [CL-1:0] r;
    ws[0] = w0;
    ws[1] = w1;
    for (int i = 0; i < CL; i++) r[i] = ws[i / WW][i % WW];
    return r;
  endfunction

  function automatic logic [WW-1:0] model_rd(input logic [CL-1:0] old,
                                             input int k);
    logic [WW-1:0] r;
    for (int j = 0; j < WW; j++)
      r[j] = (k * WW + j < CL) ? old[k * WW + j] : 1'b0;
    return r;
  endfunction

  task automatic load_chain(input logic [CL-1:0] v);
    chain_init = v;
    chain_load = 1'b1;
    step;
    chain_load = 1'b0;
  endtask

  task automatic run_pass(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                          input int gap, input bit start_mid,
                          input logic [CL-1:0] exp_bits,
                          input logic [WW-1:0] exp_rd0,
                          input logic [WW-1:0] exp_rd1,
                          input string tag);
    logic [WW-1:0] ws[2];
    logic [WW-1:0] rds[4];
    logic [CL-1:0] got;
    int idx, en_cnt, first_en, last_en, done_cyc, done_cnt;
    int busy_low, gap_left, rd_n;
    bit fin, gapping, hs;
    logic fetch_ok;
    ws[0] = w0;
    ws[1] = w1;
    got = '0;
    idx = 0; en_cnt = 0; first_en = -1; last_en = -1;
    done_cyc = -1; done_cnt = 0; busy_low = 0; gap_left = 0; rd_n = 0;
    fin = 0; gapping = 0;
    for (int i = 0; i < 4; i++) rds[i] = '0;
    start = 1'b1;
    in_valid = 1'b0;
    step;
    start = 1'b0;
    fetch_ok = (in_ready === 1'b1) && (scan_en === 1'b0) && (busy === 1'b1);
    for (int c = 0; c < 80 && !fin; c++) begin
      if (busy !== 1'b1) busy_low++;
      if (scan_en === 1'b1) begin
        if (en_cnt < CL) got[en_cnt] = scan_in;
        if (first_en < 0) first_en = c;
        last_en = c;
        en_cnt++;
      end
      if (rd_valid === 1'b1) begin
        if (rd_n < 4) rds[rd_n] = rd_data;
        rd_n++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        fin = 1;
      end
      start = start_mid && (scan_en === 1'b1) && (en_cnt == 3);
      if (idx == 1 && in_ready === 1'b1 && !gapping) begin
        gapping = 1;
        gap_left = gap;
      end
      if (!fin && idx < 2 && !(gapping && gap_left > 0)) begin
        in_valid = 1'b1;
        in_data = ws[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (gapping && gap_left > 0) gap_left--;
      hs = in_valid && (in_ready === 1'b1);
      step;
      if (hs) idx++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_fetch"}, 32'(fetch_ok), 1);
    chk({tag, "_bits"}, 32'(got), 32'(exp_bits));
    chk({tag, "_en_cnt"}, en_cnt, CL);
    chk({tag, "_en_span"}, last_en - first_en + 1, CL + gap);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_at"}, done_cyc, last_en + 1);
    chk({tag, "_busy_low"}, busy_low, 0);
    chk({tag, "_rd_cnt"}, rd_n, 2);
    chk({tag, "_rd0"}, 32'(rds[0]), 32'(exp_rd0));
    chk({tag, "_rd1"}, 32'(rds[1]), 32'(exp_rd1));
    chk({tag, "_chain"}, 32'(chain), 32'(exp_bits));
  endtask

  initial begin
    logic [WW-1:0] a, b;
    logic [CL-1:0] pre, bits1;
    int g, en_seen;
    bit hit;

    vt[0] = '{8'hA5, 8'h3C, 12'hFFF, 0, 12'hCA5, 8'hFF, 8'h0F};
    vt[1] = '{8'hA5, 8'h3C, 12'h000, 3, 12'hCA5, 8'h00, 8'h00};
    vt[2] = '{8'h00, 8'hFF, 12'hA5A, 1, 12'hF00, 8'h5A, 8'h0A};
    vt[3] = '{8'hFF, 8'h00, 12'h123, 2, 12'h0FF, 8'h23, 8'h01};

    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    step;
    start = 1'b1;
    step;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_scan_en", 32'(scan_en), 0);
    chk("rst_scan_in", 32'(scan_in), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    start = 1'b0;
    step;
    chk("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      load_chain(vt[i].pre);
      run_pass(vt[i].w0, vt[i].w1, vt[i].gap, 0, vt[i].bits,
               vt[i].rd0, vt[i].rd1, $sformatf("vec%0d", i));
      step;
    end

    for (int i = 0; i < 6; i++) begin
      a = WW'($urandom);
      b = WW'($urandom);
      pre = CL'($urandom);
      g = int'($urandom_range(0, 3));
      load_chain(pre);
      run_pass(a, b, g, 0, model_bits(a, b), model_rd(pre, 0),
               model_rd(pre, 1), $sformatf("rnd%0d", i));
    end

    load_chain(12'h5C3);
    run_pass(8'h96, 8'h0E, 0, 1, model_bits(8'h96, 8'h0E),
             model_rd(12'h5C3, 0), model_rd(12'h5C3, 1), "busy_start");
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) hit = 1;
      step;
    end
    chk("busy_start_no_rerun", 32'(hit), 0);

    load_chain(12'h0F0);
    start = 1'b1;
    step;
    start = 1'b0;
    en_seen = 0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (scan_en === 1'b1) en_seen++;
      in_valid = 1'b1;
      in_data = 8'h5A;
      if (en_seen == 6) begin
        reset = 1'b1;
        hit = 1;
      end
      step;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    chk("midrst_reached", 32'(hit), 1);
    chk("midrst_scan_en", 32'(scan_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    load_chain(12'h3A6);
    run_pass(8'hC3, 8'h09, 1, 0, model_bits(8'hC3, 8'h09),
             model_rd(12'h3A6, 0), model_rd(12'h3A6, 1), "after_rst");

    load_chain(12'h7E1);
    bits1 = model_bits(8'h4B, 8'hD2);
    run_pass(8'h4B, 8'hD2, 0, 0, bits1, model_rd(12'h7E1, 0),
             model_rd(12'h7E1, 1), "b2b_first");
    run_pass(8'h1F, 8'hE7, 0, 0, model_bits(8'h1F, 8'hE7),
             model_rd(bits1, 0), model_rd(bits1, 1), "b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
